traffic_phase_sched: RTL and testbench
======================================

TRAFFIC_PHASE_SCHED -- requirements
Module: traffic_phase_sched

Interface
REQ-001 SHALL have parameter MIN_GREEN, 4, minimum green duration in cycles (>=1).
REQ-002 SHALL have parameter MAX_GREEN, 12, green duration after which a contested green is forced to yield (>=MIN_GREEN).
REQ-003 SHALL have parameter YELLOW_T, 3, yellow duration in cycles (>=1).
REQ-004 SHALL have parameter ALLRED_T, 1, all-red clearance duration in cycles (>=1).
REQ-005 SHALL have parameter PED_T, 6, pedestrian walk duration in cycles (>=1).
REQ-006 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port ta  input  1  vehicle demand sensor, street A.
REQ-009 SHALL have port tb  input  1  vehicle demand sensor, street B.
REQ-010 SHALL have port ped_req  input  1  pedestrian request; any single-cycle pulse is latched.
REQ-011 SHALL have port la  output  2  street A light: 2'b00 GREEN, 2'b01 YELLOW, 2'b10 RED; 2'b11 never driven.
REQ-012 SHALL have port lb  output  2  street B light, same encoding.
REQ-013 SHALL have port walk  output  1  pedestrian walk indication.
REQ-014 SHALL have port phase  output  3  current state code, per REQ-016 order 0..7.

Function
REQ-015 SHALL be a Moore FSM; la, lb, walk, phase decode only the state register.
REQ-016 States: A_GRN(0), A_YEL(1), AR_AB(2), PED_AB(3), B_GRN(4), B_YEL(5), AR_BA(6), PED_BA(7).
REQ-017 Lights per state: A_GRN la=GRN/lb=RED; A_YEL la=YEL/lb=RED; B_GRN la=RED/lb=GRN; B_YEL la=RED/lb=YEL; AR_*, PED_* both RED.
REQ-018 walk SHALL be 1 only in PED_AB/PED_BA.
REQ-019 Dwell timer tmr SHALL clear to 0 on every state change, increment each cycle in state, saturate at MAX_GREEN-1; width = clog2 of the largest parameter.
REQ-020 A_GRN -> A_YEL when tmr>=MIN_GREEN-1 AND (tb OR ped_pend) AND (!ta OR tmr>=MAX_GREEN-1); else stay; B_GRN symmetric with ta/tb swapped.
REQ-021 Green with no opposing demand and no ped_pend SHALL hold indefinitely.
REQ-022 A_YEL -> AR_AB and B_YEL -> AR_BA when tmr==YELLOW_T-1.
REQ-023 AR_AB exits when tmr==ALLRED_T-1: to PED_AB if ped_pend else B_GRN; AR_BA likewise to PED_BA or A_GRN.
REQ-024 PED_AB -> B_GRN and PED_BA -> A_GRN when tmr==PED_T-1.
REQ-025 ped_pend SHALL set on ped_req in any state except PED_*, and on the transition cycle into PED_*; it clears on that transition; ped_req while in PED_* is ignored.
REQ-026 Sensor inputs are sampled only on the decision cycle; sensor changes in other cycles have no effect.

Reset
REQ-027 While rst=0: state A_GRN, tmr=0, ped_pend=0, la=2'b00, lb=2'b10, walk=0, phase=0, immediately and independent of clk.
REQ-028 Reset asserted mid-sequence (any state) SHALL abort it with no yellow/all-red completion; on release, operation restarts from A_GRN with tmr=0.

Verification (defaults; cycle 0 = first rising edge after rst release)
REQ-029 ta=1, tb=0, no ped_req for 100 cycles -> la=GRN, lb=RED, walk=0 throughout.
REQ-030 ta=0, tb=1 from cycle 0 -> la GRN cycles 0-3, YEL 4-6, both RED 7, lb GRN from cycle 8 and holding.
REQ-031 ta=1, tb=1 constant -> A green 12, yellow 3, all-red 1, B green 12, yellow 3, all-red 1; period 32 cycles, repeating.
REQ-032 ta=1, tb=0, ped_req pulse at cycle 2 -> A green cycles 0-11, YEL 12-14, RED 15, walk=1 cycles 16-21, lb GRN from cycle 22; second ped_req at cycle 18 ignored.
REQ-033 rst asserted during B_YEL, held 2 cycles -> outputs immediately la=GRN, lb=RED, walk=0; after release with ta=0, tb=1, first A_YEL at cycle 4.
REQ-034 Every cycle (assertion): la and lb never both non-RED; no GRN->RED without YEL; la/lb never 2'b11.

Source files
------------

// File: rtl/traffic_phase_sched.sv
// traffic_phase_sched: two-street signal controller with actuated greens, max-green yield and pedestrian walk phase
module traffic_phase_sched #(
  parameter int MIN_GREEN = 4,
  parameter int MAX_GREEN = 12,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 1,
  parameter int PED_T     = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ta,
  input  logic       tb,
  input  logic       ped_req,
  output logic [1:0] la,
  output logic [1:0] lb,
  output logic       walk,
  output logic [2:0] phase
);
  localparam int M1 = MIN_GREEN > MAX_GREEN ? MIN_GREEN : MAX_GREEN;
  localparam int M2 = M1 > YELLOW_T ? M1 : YELLOW_T;
  localparam int M3 = M2 > ALLRED_T ? M2 : ALLRED_T;
  localparam int MX = M3 > PED_T ? M3 : PED_T;
  localparam int TW = MX > 1 ? $clog2(MX) : 1;
  localparam logic [TW-1:0] T_MING = TW'(MIN_GREEN - 1);
  localparam logic [TW-1:0] T_MAXG = TW'(MAX_GREEN - 1);
  localparam logic [TW-1:0] T_YEL  = TW'(YELLOW_T - 1);
  localparam logic [TW-1:0] T_AR   = TW'(ALLRED_T - 1);
  localparam logic [TW-1:0] T_PED  = TW'(PED_T - 1);
  localparam logic [1:0] GRN = 2'b00, YEL = 2'b01, RED = 2'b10;
  typedef enum logic [2:0] {A_GRN, A_YEL, AR_AB, PED_AB, B_GRN, B_YEL, AR_BA, PED_BA} state_t;
  state_t state, nxt;
  logic [TW-1:0] tmr;
  logic ped_pend;
  logic in_ped, to_ped;
  // next-state decision: greens yield on opposing demand or pending walk, timed phases exit on their terminal count
  always_comb begin
    nxt = state;
    case (state)
      A_GRN:  nxt = (tmr >= T_MING && (tb || ped_pend) && (!ta || tmr >= T_MAXG)) ? A_YEL : A_GRN;
      A_YEL:  nxt = tmr == T_YEL ? AR_AB : A_YEL;
      AR_AB:  nxt = tmr == T_AR ? (ped_pend ? PED_AB : B_GRN) : AR_AB;
      PED_AB: nxt = tmr == T_PED ? B_GRN : PED_AB;
      B_GRN:  nxt = (tmr >= T_MING && (ta || ped_pend) && (!tb || tmr >= T_MAXG)) ? B_YEL : B_GRN;
      B_YEL:  nxt = tmr == T_YEL ? AR_BA : B_YEL;
      AR_BA:  nxt = tmr == T_AR ? (ped_pend ? PED_BA : A_GRN) : AR_BA;
      default: nxt = tmr == T_PED ? A_GRN : PED_BA;
    endcase
  end
  // Moore output decode straight from the state register
  always_comb begin
    in_ped = state == PED_AB || state == PED_BA;
    to_ped = (nxt == PED_AB || nxt == PED_BA) && !in_ped;
    la     = state == A_GRN ? GRN : state == A_YEL ? YEL : RED;
    lb     = state == B_GRN ? GRN : state == B_YEL ? YEL : RED;
    walk   = in_ped;
    phase  = state;
  end
  // state, saturating dwell timer and pedestrian latch; a request arriving on the entry cycle is kept for the next walk
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= A_GRN;
      tmr      <= '0;
      ped_pend <= 1'b0;
    end else begin
      state    <= nxt;
      tmr      <= nxt != state ? '0 : tmr == T_MAXG ? tmr : tmr + 1'b1;
      ped_pend <= to_ped ? ped_req : in_ped ? ped_pend : ped_pend | ped_req;
    end
  end
endmodule

// File: tb/tb_traffic_phase_sched.sv
// tb_traffic_phase_sched: scoreboard bench with a segment-level reference model, directed scenarios and random traffic
module tb_traffic_phase_sched;
  localparam int MIN_GREEN = 4, MAX_GREEN = 12, YELLOW_T = 3, ALLRED_T = 1, PED_T = 6;
  logic clk = 1'b0, rst = 1'b0, ta = 1'b0, tb = 1'b0, ped_req = 1'b0;
  logic [1:0] la, lb;
  logic walk;
  logic [2:0] phase;
  int checks = 0, errs = 0;
  logic [7:0] q[$];
  logic [7:0] lg[0:127];
  int own, seg, age;
  bit pend;

  traffic_phase_sched #(.MIN_GREEN(MIN_GREEN), .MAX_GREEN(MAX_GREEN), .YELLOW_T(YELLOW_T),
    .ALLRED_T(ALLRED_T), .PED_T(PED_T)) dut (.clk(clk), .rst(rst), .ta(ta), .tb(tb),
    .ped_req(ped_req), .la(la), .lb(lb), .walk(walk), .phase(phase));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  function automatic void m_reset();
    own = 0; seg = 0; age = 0; pend = 0;
  endfunction

  function automatic logic [7:0] m_out();
    logic [1:0] a, b;
    a = (own == 0 && seg < 2) ? 2'(seg) : 2'b10;
    b = (own == 1 && seg < 2) ? 2'(seg) : 2'b10;
    return {a, b, 1'(seg == 3), 3'(own * 4 + seg)};
  endfunction

  function automatic void m_step(bit a, bit b, bit p);
    bit mine, other, np;
    int ns, no;
    mine = own ? b : a;
    other = own ? a : b;
    ns = seg; no = own;
    case (seg)
      0: if (age + 1 >= MIN_GREEN && (other || pend) && (!mine || age + 1 >= MAX_GREEN)) ns = 1;
      1: if (age + 1 == YELLOW_T) ns = 2;
      2: if (age + 1 == ALLRED_T) begin
           if (pend) ns = 3;
           else begin ns = 0; no = 1 - own; end
         end
      default: if (age + 1 == PED_T) begin ns = 0; no = 1 - own; end
    endcase
    np = (ns == 3 && seg != 3) ? p : (seg == 3) ? pend : (pend | p);
    age = (ns != seg || no != own) ? 0 : age + 1;
    seg = ns; own = no; pend = np;
  endfunction

  task automatic cyc(input bit r, input bit a, input bit b, input bit p);
    @(negedge clk);
    rst = r; ta = a; tb = b; ped_req = p;
    if (!r) m_reset();
    q.push_back(m_out());
    if (r) m_step(a, b, p);
  endtask

  always @(negedge clk) begin
    #2;
    if (q.size() > 0) chk("outputs", {la, lb, walk, phase}, q.pop_front());
  end

  logic [1:0] pla, plb;
  bit pv = 0;
  always @(negedge clk) begin
    #2;
    if (!rst) pv = 0;
    else begin
      chk("no_11", (la == 2'b11) || (lb == 2'b11), 0);
      chk("no_conflict", la != 2'b10 && lb != 2'b10, 0);
      if (pv) chk("no_grn_red", (pla == 2'b00 && la == 2'b10) || (plb == 2'b00 && lb == 2'b10), 0);
      pla = la; plb = lb; pv = 1;
    end
  end

  task automatic run(input int n, input bit a, input bit b, input int p1, input int p2);
    for (int k = 0; k < n; k++) begin
      cyc(1, a, b, k == p1 || k == p2);
      #2;
      lg[k] = {la, lb, walk, phase};
    end
  endtask

  initial begin
    int bad, rc;
    bit ra, rb;
    m_reset();
    cyc(0, 0, 0, 0);
    #1;
    chk("reset_state", {la, lb, walk, phase}, {2'b00, 2'b10, 1'b0, 3'd0});
    cyc(0, 0, 0, 0);
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      cyc(1, 1, 0, 0);
      #2;
      if ({la, lb, walk} !== {2'b00, 2'b10, 1'b0}) bad++;
    end
    chk("r29_hold_a", bad, 0);
    cyc(0, 0, 0, 0);
    run(20, 0, 1, -1, -1);
    chk("r30_c3_la", lg[3][7:6], 2'b00);
    chk("r30_c4_la", lg[4][7:6], 2'b01);
    chk("r30_c6_la", lg[6][7:6], 2'b01);
    chk("r30_c7_ab", lg[7][7:4], 4'b1010);
    chk("r30_c8_lb", lg[8][5:4], 2'b00);
    chk("r30_c19_lb", lg[19][5:4], 2'b00);
    cyc(0, 0, 0, 0);
    run(70, 1, 1, -1, -1);
    chk("r31_c11_la", lg[11][7:6], 2'b00);
    chk("r31_c12_la", lg[12][7:6], 2'b01);
    chk("r31_c15_ph", lg[15][2:0], 3'd2);
    chk("r31_c16_lb", lg[16][5:4], 2'b00);
    chk("r31_c27_lb", lg[27][5:4], 2'b00);
    chk("r31_c28_lb", lg[28][5:4], 2'b01);
    chk("r31_c31_ph", lg[31][2:0], 3'd6);
    chk("r31_c32_la", lg[32][7:6], 2'b00);
    chk("r31_c64_la", lg[64][7:6], 2'b00);
    cyc(0, 0, 0, 0);
    run(40, 1, 0, 2, 18);
    chk("r32_c11_la", lg[11][7:6], 2'b00);
    chk("r32_c12_la", lg[12][7:6], 2'b01);
    chk("r32_c15_ph", lg[15][2:0], 3'd2);
    chk("r32_c15_walk", lg[15][3], 1'b0);
    chk("r32_c16_walk", lg[16][3], 1'b1);
    chk("r32_c21_walk", lg[21][3], 1'b1);
    chk("r32_c22_lb", lg[22][5:4], 2'b00);
    chk("r32_c22_walk", lg[22][3], 1'b0);
    chk("r32_c30_la", lg[30][7:6], 2'b00);
    chk("r32_c30_walk", lg[30][3], 1'b0);
    cyc(0, 0, 0, 0);
    run(8, 0, 1, -1, -1);
    run(5, 1, 0, -1, -1);
    chk("r33_byel", lg[4][2:0], 3'd5);
    @(negedge clk);
    rst = 0; m_reset();
    q.push_back(m_out());
    #1;
    chk("r33_async", {la, lb, walk, phase}, {2'b00, 2'b10, 1'b0, 3'd0});
    cyc(0, 0, 1, 0);
    run(10, 0, 1, -1, -1);
    chk("r33_c3_la", lg[3][7:6], 2'b00);
    chk("r33_c4_la", lg[4][7:6], 2'b01);
    ra = 0; rb = 0; rc = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) ra = ~ra;
      if ($urandom_range(7) == 0) rb = ~rb;
      if (rc == 0 && $urandom_range(249) == 0) rc = $urandom_range(3, 1);
      cyc(rc == 0, ra, rb, $urandom_range(24) == 0);
      if (rc > 0) rc--;
    end
    cyc(1, 0, 0, 0);
    @(negedge clk);
    #3;
    chk("drain", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
